// File: rtl/maquina_pkg.sv
// Shared types and default phase durations for the washing-machine cycle timer.
package maquina_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        AGITANDO    = 2'd1,
        ESPERA_GIRO = 2'd2,
        GIRANDO     = 2'd3
    } estado_temporizador_t;

    localparam int TEMPO_AGITAR_PADRAO = 1000;
    localparam int TEMPO_GIRAR_PADRAO  = 500;

endpackage

// File: rtl/temporizador_ciclo_contador.sv
// Saturating down-counter with synchronous load; stops at zero instead of wrapping.
module contador_decrescente #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_carga,
    input  logic [WIDTH-1:0] i_valor,
    input  logic             i_habilita,
    output logic [WIDTH-1:0] o_contagem,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_carga) begin
            r_contagem <= i_valor;
        end else if (i_habilita && (r_contagem != '0)) begin
            r_contagem <= r_contagem - WIDTH'(1);
        end
    end

    assign o_contagem = r_contagem;
    assign o_zero     = (r_contagem == '0);

endmodule

// File: rtl/temporizador_ciclo.sv
// Agitation/spin phase timer producing the tempo and secar conditions for the sequencer.
module temporizador_ciclo
    import maquina_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int TEMPO_AGITAR = TEMPO_AGITAR_PADRAO,
    parameter int TEMPO_GIRAR  = TEMPO_GIRAR_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             modo_agitar,
    input  logic             modo_girar,
    input  logic             pausa,
    output logic             tempo,
    output logic             secar,
    output logic [WIDTH-1:0] restante
);

    // Loading duration-1 lets a full 2**WIDTH-cycle phase fit the counter.
    localparam logic [WIDTH-1:0] CARGA_AGITAR = WIDTH'(TEMPO_AGITAR - 1);
    localparam logic [WIDTH-1:0] CARGA_GIRAR  = WIDTH'(TEMPO_GIRAR - 1);

    estado_temporizador_t r_estado, w_estado_next;
    logic                 r_tempo, w_tempo_next;
    logic                 r_secar, w_secar_next;
    logic                 w_carga;
    logic [WIDTH-1:0]     w_valor;
    logic                 w_habilita;
    logic                 w_zero;
    logic [WIDTH-1:0]     w_contagem;

    contador_decrescente #(
        .WIDTH (WIDTH)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .i_carga    (w_carga),
        .i_valor    (w_valor),
        .i_habilita (w_habilita),
        .o_contagem (w_contagem),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_tempo  <= 1'b0;
            r_secar  <= 1'b0;
        end else begin
            r_estado <= w_estado_next;
            r_tempo  <= w_tempo_next;
            r_secar  <= w_secar_next;
        end
    end

    // Every return to OCIOSO reloads zero so restante reads 0 while idle.
    always_comb begin
        w_estado_next = r_estado;
        w_tempo_next  = r_tempo;
        w_secar_next  = r_secar;
        w_carga       = 1'b0;
        w_valor       = '0;
        w_habilita    = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                w_tempo_next = 1'b0;
                w_secar_next = 1'b0;
                if (modo_agitar && !modo_girar) begin
                    w_carga       = 1'b1;
                    w_valor       = CARGA_AGITAR;
                    w_estado_next = AGITANDO;
                end
            end
            AGITANDO: begin
                if (!modo_agitar || modo_girar) begin
                    w_carga       = 1'b1;
                    w_tempo_next  = 1'b0;
                    w_secar_next  = 1'b0;
                    w_estado_next = OCIOSO;
                end else if (pausa) begin
                    w_habilita = 1'b0;
                end else if (!w_zero) begin
                    w_habilita = 1'b1;
                end else begin
                    w_tempo_next  = 1'b1;
                    w_secar_next  = 1'b1;
                    w_estado_next = ESPERA_GIRO;
                end
            end
            ESPERA_GIRO: begin
                if (modo_girar && !modo_agitar) begin
                    w_carga       = 1'b1;
                    w_valor       = CARGA_GIRAR;
                    w_tempo_next  = 1'b0;
                    w_secar_next  = 1'b1;
                    w_estado_next = GIRANDO;
                end else if (modo_girar == modo_agitar) begin
                    w_carga       = 1'b1;
                    w_tempo_next  = 1'b0;
                    w_secar_next  = 1'b0;
                    w_estado_next = OCIOSO;
                end
            end
            GIRANDO: begin
                if (!modo_girar) begin
                    w_carga       = 1'b1;
                    w_secar_next  = 1'b0;
                    w_estado_next = OCIOSO;
                end else if (pausa) begin
                    w_habilita = 1'b0;
                end else if (!w_zero) begin
                    w_habilita = 1'b1;
                end else begin
                    w_carga       = 1'b1;
                    w_secar_next  = 1'b0;
                    w_estado_next = OCIOSO;
                end
            end
            default: begin
                w_carga       = 1'b1;
                w_tempo_next  = 1'b0;
                w_secar_next  = 1'b0;
                w_estado_next = OCIOSO;
            end
        endcase
    end

    assign tempo    = r_tempo;
    assign secar    = r_secar;
    assign restante = w_contagem;

endmodule

// File: tb/tb_temporizador_ciclo.sv
// Directed bench: main instance with 4/3-cycle phases, second instance with 1-cycle agitation.
module tb_temporizador_ciclo;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             modo_agitar = 1'b0;
    logic             modo_girar = 1'b0;
    logic             pausa = 1'b0;
    logic             tempo, secar;
    logic [WIDTH-1:0] restante;
    logic             tempo_1, secar_1;
    logic [WIDTH-1:0] restante_1;

    int n_comp = 0;
    int n_erro = 0;

    always #5 clock = ~clock;

    temporizador_ciclo #(
        .WIDTH(WIDTH), .TEMPO_AGITAR(4), .TEMPO_GIRAR(3)
    ) dut (
        .clock(clock), .reset(reset), .modo_agitar(modo_agitar),
        .modo_girar(modo_girar), .pausa(pausa),
        .tempo(tempo), .secar(secar), .restante(restante)
    );

    temporizador_ciclo #(
        .WIDTH(WIDTH), .TEMPO_AGITAR(1), .TEMPO_GIRAR(1)
    ) dut_1 (
        .clock(clock), .reset(reset), .modo_agitar(modo_agitar),
        .modo_girar(modo_girar), .pausa(pausa),
        .tempo(tempo_1), .secar(secar_1), .restante(restante_1)
    );

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_erro++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic checa(input string tag, input logic t, input logic s, input int r);
        verificar({tag, ".tempo"}, 32'(tempo), 32'(t));
        verificar({tag, ".secar"}, 32'(secar), 32'(s));
        verificar({tag, ".restante"}, 32'(restante), 32'(r));
    endtask

    task automatic agita_ate_espera(input string tag);
        modo_agitar = 1'b1;
        repeat (5) passo();
        verificar({tag, ".tempo_pronto"}, 32'(tempo), 32'd1);
        modo_agitar = 1'b0;
        modo_girar  = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clock);
        #1;
        checa("reset", 1'b0, 1'b0, 0);
        reset = 1'b0;
        passo();

        // Basic agitation, TEMPO_AGITAR=4
        modo_agitar = 1'b1;
        passo(); checa("agit.k",   0, 0, 3);
        passo(); checa("agit.k1",  0, 0, 2);
        passo(); checa("agit.k2",  0, 0, 1);
        passo(); checa("agit.k3",  0, 0, 0);
        passo(); checa("agit.k4",  1, 1, 0);
        // Full cycle: spin, TEMPO_GIRAR=3
        modo_agitar = 1'b0;
        modo_girar  = 1'b1;
        passo(); checa("giro.m",   0, 1, 2);
        passo(); checa("giro.m1",  0, 1, 1);
        passo(); checa("giro.m2",  0, 1, 0);
        passo(); checa("giro.m3",  0, 0, 0);
        modo_girar = 1'b0;
        passo();

        // Pause during agitation
        modo_agitar = 1'b1;
        passo(); checa("pausaA.k",  0, 0, 3);
        passo(); checa("pausaA.k1", 0, 0, 2);
        pausa = 1'b1;
        passo(); checa("pausaA.p1", 0, 0, 2);
        passo(); checa("pausaA.p2", 0, 0, 2);
        pausa = 1'b0;
        passo(); checa("pausaA.k4", 0, 0, 1);
        passo(); checa("pausaA.k5", 0, 0, 0);
        passo(); checa("pausaA.k6", 1, 1, 0);
        // Pause during spin
        modo_agitar = 1'b0;
        modo_girar  = 1'b1;
        passo(); checa("pausaG.m",  0, 1, 2);
        pausa = 1'b1;
        passo(); checa("pausaG.p1", 0, 1, 2);
        passo(); checa("pausaG.p2", 0, 1, 2);
        pausa = 1'b0;
        passo(); checa("pausaG.m3", 0, 1, 1);
        passo(); checa("pausaG.m4", 0, 1, 0);
        passo(); checa("pausaG.m5", 0, 0, 0);
        modo_girar = 1'b0;
        passo();

        // Abort agitation with restante=2
        modo_agitar = 1'b1;
        passo(); passo(); checa("abortA.pre", 0, 0, 2);
        modo_agitar = 1'b0;
        passo(); checa("abortA.pos", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            passo();
            verificar("abortA.sem_tempo", 32'(tempo), 32'd0);
        end

        // Abort spin
        agita_ate_espera("abortG");
        passo(); checa("abortG.m", 0, 1, 2);
        modo_girar = 1'b0;
        passo(); checa("abortG.pos", 0, 0, 0);

        // Both modes high in AGITANDO
        modo_agitar = 1'b1;
        passo(); checa("ambos.k", 0, 0, 3);
        modo_girar = 1'b1;
        passo(); checa("ambos.pos", 0, 0, 0);
        passo(); checa("ambos.ocioso", 0, 0, 0);
        modo_agitar = 1'b0;
        modo_girar  = 1'b0;
        passo();

        // Abort coincident with counter==0
        modo_agitar = 1'b1;
        repeat (4) passo();
        checa("abortZ.pre", 0, 0, 0);
        modo_agitar = 1'b0;
        passo(); checa("abortZ.pos", 0, 0, 0);
        passo(); checa("abortZ.ocioso", 0, 0, 0);

        // TEMPO_AGITAR=1 on the second instance
        modo_agitar = 1'b1;
        passo();
        verificar("t1.k.tempo", 32'(tempo_1), 32'd0);
        verificar("t1.k.restante", 32'(restante_1), 32'd0);
        passo();
        verificar("t1.k1.tempo", 32'(tempo_1), 32'd1);
        verificar("t1.k1.secar", 32'(secar_1), 32'd1);
        modo_agitar = 1'b0;
        passo();
        verificar("t1.ocioso.tempo", 32'(tempo_1), 32'd0);
        passo();

        // Pause in OCIOSO has no effect on starting agitation
        pausa = 1'b1;
        modo_agitar = 1'b1;
        passo(); checa("pausaO.k", 0, 0, 3);
        pausa = 1'b0;
        modo_agitar = 1'b0;
        passo();

        // Asynchronous reset mid-spin
        agita_ate_espera("rst");
        passo(); checa("rst.m", 0, 1, 2);
        #2 reset = 1'b1;
        #1 checa("rst.async", 0, 0, 0);
        modo_girar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        passo(); checa("rst.pos", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/temporizador_ciclo.md
# temporizador_ciclo

- Generates the `tempo` and `secar` condition inputs for the washing-machine sequencer.
- Sits directly upstream of the sequencer and consumes its `modo_agitar` / `modo_girar` mode outputs.
- Times the agitation phase: raises `tempo` after a programmable number of cycles.
- Times the spin phase: holds `secar` high for a programmable number of cycles, then drops it so the sequencer returns to idle.

## Interface
- `WIDTH`, 16: counter width in bits.
- `TEMPO_AGITAR`, 1000: agitation duration in clock cycles. Legal range 1..2**WIDTH.
- `TEMPO_GIRAR`, 500: spin duration in clock cycles. Legal range 1..2**WIDTH.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `modo_agitar`  in  1  sequencer is in its agitation state.
- `modo_girar`  in  1  sequencer is in its spin state.
- `pausa`  in  1  lid open: freezes the counter, does not block aborts.
- `tempo`  out  1  agitation finished. Registered level.
- `secar`  out  1  spin still required. Registered level.
- `restante`  out  WIDTH  current counter value; 0 in OCIOSO.

## Operation
State machine with four states, evaluated on each rising edge:
- **OCIOSO**
  - Outputs: `tempo`=0, `secar`=0, `restante`=0.
  - `modo_agitar`=1 and `modo_girar`=0: load counter with TEMPO_AGITAR-1, go to AGITANDO.
- **AGITANDO**
  - `modo_agitar`=0, or both modes 1: go to OCIOSO (abort).
  - Else, `pausa`=1: hold.
  - Else, counter>0: decrement.
  - Else (counter==0): set `tempo`<=1 and `secar`<=1, go to ESPERA_GIRO.
- **ESPERA_GIRO**
  - `tempo`=1 and `secar`=1 held.
  - `modo_girar`=1 and `modo_agitar`=0: load counter with TEMPO_GIRAR-1, set `tempo`<=0, keep `secar`=1, go to GIRANDO.
  - Both modes 0: go to OCIOSO, clear both outputs.
  - Both modes 1: go to OCIOSO, clear both outputs.
- **GIRANDO**
  - `modo_girar`=0: go to OCIOSO, `secar`<=0 (abort).
  - Else, `pausa`=1: hold.
  - Else, counter>0: decrement.
  - Else (counter==0): set `secar`<=0, go to OCIOSO.

Arithmetic and width rules:
- Counter is WIDTH-bit unsigned. It only decrements and never wraps below 0.
- Load values are the parameters minus 1, so 2**WIDTH fits in WIDTH bits.
- `restante` reflects the counter register directly.

Ordering guarantee:
- `secar` is raised together with `tempo`.
- Therefore `secar`=1 is already stable when the sequencer first samples it in its spin state; the sequencer cannot fall straight through to idle.

## Timing
- Reset (asynchronous assert, synchronous release): state OCIOSO, `tempo`=0, `secar`=0, `restante`=0.
- Reset mid-phase discards the count. No state is retained.
- Agitation latency:
  - Edge k is the first OCIOSO edge sampling `modo_agitar`=1.
  - With no pause, `tempo` is 1 after edge k+TEMPO_AGITAR.
  - Each pause cycle adds exactly one cycle.
- Spin latency:
  - Edge m is the first ESPERA_GIRO edge sampling `modo_girar`=1.
  - `tempo` falls after edge m.
  - `secar` falls after edge m+TEMPO_GIRAR, plus one per pause cycle.
- TEMPO_*=1: phase ends at the first edge after the load.
- Abort takes priority over `pausa` and over counter==0 in the same cycle.
- `pausa` asserted in OCIOSO or ESPERA_GIRO has no effect.

## Structure
- Package `maquina_pkg` holds:
  - enum `estado_temporizador_t` (OCIOSO, AGITANDO, ESPERA_GIRO, GIRANDO);
  - default duration constants `TEMPO_AGITAR_PADRAO`=1000 and `TEMPO_GIRAR_PADRAO`=500.
- One natural sub-module, `contador_decrescente`:
  - parameter WIDTH;
  - ports: load, load value, enable, count, zero flag.
- The FSM and output registers stay in `temporizador_ciclo`.

## Test plan
- Basic agitation: reset, then `modo_agitar`=1 with TEMPO_AGITAR=4 → `tempo` rises exactly 4 edges after the first sampled edge, and `secar` rises in the same cycle.
- Full cycle: continue with `modo_girar`=1, TEMPO_GIRAR=3 → `tempo` falls 1 edge later, `secar` falls 3 edges after the first sampled `modo_girar`, state returns to OCIOSO with `restante`=0.
- Pause: `pausa`=1 for 2 cycles mid-agitation → `tempo` delayed by exactly 2 cycles and `restante` constant during the pause. Repeat during spin and check `secar` is delayed by 2.
- Abort:
  - drop `modo_agitar` with `restante`=2 → OCIOSO next edge, `tempo` never asserts;
  - drop `modo_girar` mid-spin → `secar`=0 next edge.
- Boundaries:
  - TEMPO_AGITAR=1 → `tempo` after 1 edge;
  - both modes 1 in AGITANDO → OCIOSO;
  - abort coincident with counter==0 → no `tempo`.
- Asynchronous reset mid-spin with `secar`=1 → `secar`, `tempo` and `restante` go to 0 without waiting for a clock edge.
